// File: rtl/shift_arbiter_if.sv
// Request/response bundle for the shared shift unit: two requesters in,
// one registered result out.
interface shift_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [2:0]  req_op0;
    logic [2:0]  req_op1;
    logic [7:0]  req_amt0;
    logic [7:0]  req_amt1;
    logic        req_cin0;
    logic        req_cin1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_id;

    // Requesters and result consumer side.
    modport master (
        output req_valid, req_a0, req_a1, req_op0, req_op1,
               req_amt0, req_amt1, req_cin0, req_cin1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_id
    );

    // Shift unit side.
    modport slave (
        input  req_valid, req_a0, req_a1, req_op0, req_op1,
               req_amt0, req_amt1, req_cin0, req_cin1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_id
    );
endinterface

// File: rtl/shift_arbiter.sv
// Shared ARM register-specified shifter. Round-robin arbitration between two
// requesters, single-entry registered output with valid/ready handshake.
module shift_arbiter (
    input  logic            clk,
    input  logic            reset,
    shift_arbiter_if.slave  bus
);

    // Returns {carry, result} for one ARM register-specified shift.
    function automatic logic [32:0] shift_calc(
        input logic [31:0] a,
        input logic [2:0]  op,
        input logic [7:0]  amt,
        input logic        cin
    );
        logic [32:0] res;
        logic [32:0] t;
        logic [63:0] rot;
        logic        big;
        logic        is32;
        logic [4:0]  n5;
        res  = {cin, a};
        t    = '0;
        rot  = '0;
        n5   = amt[4:0];
        big  = |amt[7:5];
        is32 = (amt == 8'd32);
        if (op == 3'd4) begin
            // RRX ignores the amount entirely.
            res = {a[0], cin, a[31:1]};
        end else if (amt != 8'd0) begin
            case (op)
                3'd0: begin
                    if (big) begin
                        res = {is32 & a[0], 32'h0};
                    end else begin
                        // Bit 32 of the widened shift is the last bit shifted out.
                        t   = {1'b0, a} << n5;
                        res = t;
                    end
                end
                3'd1: begin
                    if (big) begin
                        res = {is32 & a[31], 32'h0};
                    end else begin
                        t   = {a, 1'b0} >> n5;
                        res = {t[0], t[32:1]};
                    end
                end
                3'd2: begin
                    if (big) begin
                        res = {a[31], {32{a[31]}}};
                    end else begin
                        t   = $unsigned($signed({a, 1'b0}) >>> n5);
                        res = {t[0], t[32:1]};
                    end
                end
                3'd3: begin
                    // Rotating by a multiple of 32 leaves a, and bit 31 is
                    // always the last bit rotated out.
                    rot = {a, a} >> n5;
                    res = {rot[31], rot[31:0]};
                end
                default: res = {cin, a};
            endcase
        end
        return res;
    endfunction

    logic        r_rsp_valid;
    logic [31:0] r_rsp_result;
    logic        r_rsp_carry;
    logic        r_rsp_id;
    logic        r_last_id;

    logic        w_any;
    logic        w_both;
    logic        w_sel;
    logic        w_can;
    logic        w_xfer;
    logic [31:0] w_a;
    logic [2:0]  w_op;
    logic [7:0]  w_amt;
    logic        w_cin;
    logic [32:0] w_shift;

    // Round-robin grant and operand selection for the winning requester.
    always_comb begin
        w_any  = |bus.req_valid;
        w_both = &bus.req_valid;
        w_sel  = w_both ? ~r_last_id : bus.req_valid[1];
        w_can  = ~r_rsp_valid | bus.rsp_ready;
        w_xfer = w_any & w_can;
        bus.req_ready = 2'b00;
        if (w_xfer) begin
            bus.req_ready = w_sel ? 2'b10 : 2'b01;
        end
        w_a     = w_sel ? bus.req_a1   : bus.req_a0;
        w_op    = w_sel ? bus.req_op1  : bus.req_op0;
        w_amt   = w_sel ? bus.req_amt1 : bus.req_amt0;
        w_cin   = w_sel ? bus.req_cin1 : bus.req_cin0;
        w_shift = shift_calc(w_a, w_op, w_amt, w_cin);
    end

    // Output register and last-granted pointer; a load wins over a drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 32'h0;
            r_rsp_carry  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_last_id    <= 1'b1;
        end else if (w_xfer) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= w_shift[31:0];
            r_rsp_carry  <= w_shift[32];
            r_rsp_id     <= w_sel;
            r_last_id    <= w_sel;
        end else if (bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_id     = r_rsp_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: shift corners, contention, backpressure
// and asynchronous reset.
module tb_shift_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    shift_arbiter_if bus ();

    shift_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single request from requester r; checks ready, then the registered result.
    task automatic send(input string tag, input logic r, input logic [31:0] a,
                        input logic [2:0] op, input logic [7:0] amt, input logic cin,
                        input logic [31:0] exp_res, input logic exp_c);
        if (r) begin
            bus.req_a1 = a; bus.req_op1 = op; bus.req_amt1 = amt; bus.req_cin1 = cin;
            bus.req_valid = 2'b10;
        end else begin
            bus.req_a0 = a; bus.req_op0 = op; bus.req_amt0 = amt; bus.req_cin0 = cin;
            bus.req_valid = 2'b01;
        end
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), r ? 32'd2 : 32'd1);
        step();
        bus.req_valid = 2'b00;
        chk({tag, "_valid"},  32'(bus.rsp_valid), 32'd1);
        chk({tag, "_result"}, bus.rsp_result, exp_res);
        chk({tag, "_carry"},  32'(bus.rsp_carry), 32'(exp_c));
        chk({tag, "_id"},     32'(bus.rsp_id), 32'(r));
    endtask

    initial begin
        logic [1:0] exp_rdy [4];
        logic       exp_id  [4];
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a0 = '0; bus.req_op0 = '0; bus.req_amt0 = '0; bus.req_cin0 = 1'b0;
        bus.req_a1 = '0; bus.req_op1 = '0; bus.req_amt1 = '0; bus.req_cin1 = 1'b0;
        bus.rsp_ready = 1'b1;
        #12;
        chk("rst_valid",  32'(bus.rsp_valid), 32'd0);
        chk("rst_result", bus.rsp_result, 32'h0);
        chk("rst_carry",  32'(bus.rsp_carry), 32'd0);
        chk("rst_id",     32'(bus.rsp_id), 32'd0);
        reset = 1'b0;
        step();

        send("lsl1",    1'b0, 32'h80000001, 3'd0, 8'd1,  1'b0, 32'h00000002, 1'b1);
        send("lsr32",   1'b0, 32'h80000000, 3'd1, 8'd32, 1'b0, 32'h00000000, 1'b1);
        send("lsl33",   1'b1, 32'hFFFFFFFF, 3'd0, 8'd33, 1'b1, 32'h00000000, 1'b0);
        send("asr40",   1'b0, 32'h80000000, 3'd2, 8'd40, 1'b0, 32'hFFFFFFFF, 1'b1);
        send("lsl0",    1'b1, 32'h00001234, 3'd0, 8'd0,  1'b1, 32'h00001234, 1'b1);
        send("ror4",    1'b0, 32'h0000000F, 3'd3, 8'd4,  1'b0, 32'hF0000000, 1'b1);
        send("ror32",   1'b1, 32'h80000001, 3'd3, 8'd32, 1'b0, 32'h80000001, 1'b1);
        send("rrx",     1'b0, 32'h00000003, 3'd4, 8'd9,  1'b1, 32'h80000001, 1'b1);
        send("asr4",    1'b0, 32'h80000010, 3'd2, 8'd4,  1'b1, 32'hF8000001, 1'b0);
        send("lsl32",   1'b0, 32'h00000001, 3'd0, 8'd32, 1'b0, 32'h00000000, 1'b1);
        send("lsr40",   1'b0, 32'hFFFFFFFF, 3'd1, 8'd40, 1'b1, 32'h00000000, 1'b0);
        send("lsr5",    1'b0, 32'h000000F0, 3'd1, 8'd5,  1'b0, 32'h00000007, 1'b1);
        send("ror36",   1'b0, 32'h00000018, 3'd3, 8'd36, 1'b0, 32'h80000001, 1'b1);
        send("pass5",   1'b1, 32'h0000ABCD, 3'd5, 8'd7,  1'b0, 32'h0000ABCD, 1'b0);

        // Contention: last grant went to requester 1, so 0 goes first.
        bus.req_a0 = 32'h11111111; bus.req_op0 = 3'd5; bus.req_amt0 = 8'd0; bus.req_cin0 = 1'b0;
        bus.req_a1 = 32'h22222222; bus.req_op1 = 3'd5; bus.req_amt1 = 8'd0; bus.req_cin1 = 1'b1;
        bus.req_valid = 2'b11;
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_ready%0d", i), 32'(bus.req_ready), 32'(exp_rdy[i]));
            step();
            chk($sformatf("rr_id%0d", i), 32'(bus.rsp_id), 32'(exp_id[i]));
            chk($sformatf("rr_res%0d", i), bus.rsp_result,
                exp_id[i] ? 32'h22222222 : 32'h11111111);
            chk($sformatf("rr_carry%0d", i), 32'(bus.rsp_carry), 32'(exp_id[i]));
        end

        // Backpressure with requester 0 pending.
        bus.rsp_ready = 1'b0;
        bus.req_a0 = 32'h00000010; bus.req_op0 = 3'd0; bus.req_amt0 = 8'd4; bus.req_cin0 = 1'b1;
        bus.req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_ready%0d", i), 32'(bus.req_ready), 32'd0);
            chk($sformatf("bp_valid%0d", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp_res%0d", i), bus.rsp_result, 32'h22222222);
            chk($sformatf("bp_id%0d", i), 32'(bus.rsp_id), 32'd1);
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 2'b00;
        chk("bp_load_valid",  32'(bus.rsp_valid), 32'd1);
        chk("bp_load_result", bus.rsp_result, 32'h00000100);
        chk("bp_load_carry",  32'(bus.rsp_carry), 32'd0);
        chk("bp_load_id",     32'(bus.rsp_id), 32'd0);

        // Move the round-robin pointer to 0, then reset with a result held.
        send("pre_rst", 1'b0, 32'h00000001, 3'd0, 8'd1, 1'b0, 32'h00000002, 1'b0);
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid",  32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_result", bus.rsp_result, 32'h0);
        bus.req_a0 = 32'h0000000A; bus.req_op0 = 3'd6; bus.req_amt0 = 8'd0;
        bus.req_a1 = 32'h0000000B; bus.req_op1 = 3'd6; bus.req_amt1 = 8'd0;
        bus.req_valid = 2'b11;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 2'b00;
        chk("post_rst_valid",  32'(bus.rsp_valid), 32'd1);
        chk("post_rst_id",     32'(bus.rsp_id), 32'd0);
        chk("post_rst_result", bus.rsp_result, 32'h0000000A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Registered shift unit shared between two requesters (execute-stage operand-2 path and load/store address-offset path). Arbitrates round-robin between the requesters and computes the full ARM register-specified shift, with 8-bit amounts and the carry-out rules for amounts of 0, 32 and more than 32. Returns the result and carry through a single-entry output register with a valid/ready handshake. Sits between decode/operand fetch and the ALU/AGU.

## Interface
- Parameters: none. Datapath is fixed at 32 bits with two requesters.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  2  per-requester request valid; bit i belongs to requester i
- req_ready  out  2  per-requester accept; a request transfers when valid[i] & ready[i]
- req_a0, req_a1  in  32  operand
- req_op0, req_op1  in  3  opcode: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5–7 pass-through
- req_amt0, req_amt1  in  8  shift amount, 0–255
- req_cin0, req_cin1  in  1  current C flag
- rsp_valid  out  1  output register holds a result
- rsp_ready  in  1  consumer accepts the result
- rsp_result  out  32  shifted value
- rsp_carry  out  1  shifter carry-out
- rsp_id  out  1  requester index the result belongs to

## Operation
- can_accept = !rsp_valid | rsp_ready.
- Grant is combinational, round-robin:
  - last_id register holds the index of the last requester granted.
  - If both requesters are valid, grant goes to the requester other than last_id.
  - If only one is valid, that one is granted.
- req_ready[i] = grant[i] & can_accept. At most one bit of req_ready is high in any cycle.
- Requesters must not make req_valid depend on req_ready. Once a requester raises valid, it holds valid and its request fields stable until accepted.
- On transfer: the output register loads result, carry and id; last_id ← granted index.
- Shift rules (n = amt, c = cin):
  - n==0, any op except RRX: result=a, carry=c.
  - LSL:
    - n in 1–31: a<<n, carry=a[32-n].
    - n==32: 0, carry=a[0].
    - n>32: 0, carry=0.
  - LSR:
    - n in 1–31: a>>n, carry=a[n-1].
    - n==32: 0, carry=a[31].
    - n>32: 0, carry=0.
  - ASR:
    - n in 1–31: arithmetic shift right, carry=a[n-1].
    - n≥32: every bit = a[31], carry=a[31].
  - ROR, with r = n[4:0]:
    - r==0 and n≠0: result=a, carry=a[31].
    - otherwise: rotate right by r, carry=a[r-1].
  - RRX: amt ignored; result={c, a[31:1]}, carry=a[0].
  - Ops 5–7: result=a, carry=c.
- Output register:
  - rsp_valid set on transfer.
  - rsp_valid cleared when rsp_ready is high and no new transfer occurs in the same cycle.
  - Drain and load in the same cycle replaces the contents; no bubble.
  - Contents hold unchanged while rsp_valid & !rsp_ready.

## Timing
- Reset values:
  - rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_id=0.
  - last_id=1, so requester 0 wins the first contention.
  - req_ready follows its combinational equation; with rsp_valid=0, a valid requester sees ready in the first cycle after reset.
- Latency: request accepted in cycle t → rsp_valid=1 with its result in cycle t+1.
- Throughput: one result per cycle while rsp_ready stays high.
- Backpressure: while rsp_valid & !rsp_ready, both req_ready bits are 0 and last_id does not change.
- Reset asserted mid-operation: the pending result is discarded, rsp_valid drops immediately (asynchronous), and last_id returns to 1.

## Test plan
- Single requester, one request: requester 0 sends LSL, a=0x80000001, amt=1 → next cycle rsp_result=0x00000002, carry=1, id=0.
- Large-amount and zero-amount corners:
  - LSR, amt=32, a=0x80000000 → 0x00000000, carry=1.
  - LSL, amt=33 → 0, carry=0.
  - ASR, amt=40, a=0x80000000 → 0xFFFFFFFF, carry=1.
  - LSL, amt=0, cin=1, a=0x1234 → 0x1234, carry=1.
- ROR and RRX:
  - ROR, amt=4, a=0x0000000F → 0xF0000000, carry=1.
  - ROR, amt=32, a=0x80000001 → 0x80000001, carry=1.
  - RRX, cin=1, a=0x00000003 → 0x80000001, carry=1.
- Contention: both requesters held valid for 4 cycles with rsp_ready=1 → accepts alternate 0,1,0,1; rsp_id sequence is 0,1,0,1, starting one cycle after the first accept.
- Backpressure: rsp_ready=0 for 3 cycles with a result held → rsp fields stable, req_ready=00 throughout. Raise rsp_ready with a request pending → drain and accept in the same cycle, with no bubble.
- Reset mid-stream: assert reset while rsp_valid=1 → rsp_valid=0 immediately. After release, with both requesters valid, requester 0 is granted first.
